// File: rtl/wb_bus_arbiter.sv
`timescale 1ns/1ps
// Two-master round-robin Wishbone arbiter in front of the user-project address decoder,
// with a per-transfer ack watchdog that turns a hung slave into an error pulse.
module wb_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [3:0]      m0_sel_i,
    input  logic [31:0]     m0_adr_i,
    input  logic [31:0]     m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [3:0]      m1_sel_i,
    input  logic [31:0]     m1_adr_i,
    input  logic [31:0]     m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [31:0]     m_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [3:0]      s_sel_o,
    output logic [31:0]     s_adr_o,
    output logic [31:0]     s_dat_o,
    input  logic            s_ack_i,
    input  logic [31:0]     s_dat_i,
    output logic [1:0]      gnt_o,
    output logic [TO_W-1:0] to_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

    state_t          r_state;
    state_t          w_state_next;
    logic            r_owner;
    logic            w_owner_next;
    logic            r_last;
    logic            w_last_next;
    logic [TO_W-1:0] r_wd;
    logic [TO_W-1:0] w_wd_next;
    logic [TO_W-1:0] r_to_count;
    logic [TO_W-1:0] w_to_count_next;

    logic [1:0]      w_cyc;
    logic [1:0]      w_stb;
    logic [1:0]      w_we;
    logic [1:0]      w_req;
    logic [1:0]      w_ack;
    logic [1:0]      w_err;
    logic [3:0]      w_sel [2];
    logic [31:0]     w_adr [2];
    logic [31:0]     w_dat [2];

    logic            w_busy;
    logic            w_in_err;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_stall;
    logic            w_winner;

    assign w_cyc    = {m1_cyc_i, m0_cyc_i};
    assign w_stb    = {m1_stb_i, m0_stb_i};
    assign w_we     = {m1_we_i,  m0_we_i};
    assign w_sel[0] = m0_sel_i;
    assign w_sel[1] = m1_sel_i;
    assign w_adr[0] = m0_adr_i;
    assign w_adr[1] = m1_adr_i;
    assign w_dat[0] = m0_dat_i;
    assign w_dat[1] = m1_dat_i;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_in_err  = (r_state == ST_ERR);
    assign w_own_cyc = w_cyc[r_owner];
    assign w_own_stb = w_busy & w_stb[r_owner];
    assign w_stall   = w_own_stb & ~s_ack_i;

    // On a tie the master that did not win the previous contest goes first.
    assign w_winner = (w_req == 2'b11) ? ~r_last : w_req[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam logic IDX = 1'(gi);
            assign w_req[gi] = w_cyc[gi] & w_stb[gi];
            assign w_ack[gi] = w_busy & (r_owner == IDX) & s_ack_i;
            assign w_err[gi] = w_in_err & (r_owner == IDX);
        end
    endgenerate

    assign m0_ack_o = w_ack[0];
    assign m1_ack_o = w_ack[1];
    assign m0_err_o = w_err[0];
    assign m1_err_o = w_err[1];

    // Owner's bus passes straight through; outside BUSY the decoder sees an idle bus.
    always_comb begin : p_slave_mux
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'd0;
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        if (w_busy) begin
            s_cyc_o = w_own_cyc;
            s_stb_o = w_own_stb;
            s_we_o  = w_we[r_owner];
            s_sel_o = w_sel[r_owner];
            s_adr_o = w_adr[r_owner];
            s_dat_o = w_dat[r_owner];
        end
    end

    assign m_dat_o    = (w_busy & s_ack_i) ? s_dat_i : 32'd0;
    assign gnt_o      = (w_busy | w_in_err) ? {r_owner, ~r_owner} : 2'b00;
    assign to_count_o = r_to_count;

    always_comb begin : p_next
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_last_next     = r_last;
        w_wd_next       = r_wd;
        w_to_count_next = r_to_count;
        case (r_state)
            ST_IDLE: begin
                w_wd_next = '0;
                if (|w_req) begin
                    w_owner_next = w_winner;
                    w_last_next  = w_winner;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc) begin
                    w_wd_next    = '0;
                    w_state_next = ST_IDLE;
                end else if (w_stall) begin
                    // A stall on the last allowed cycle expires; an ack in that cycle wins.
                    if (r_wd == WD_LAST) begin
                        w_wd_next    = '0;
                        w_state_next = ST_ERR;
                    end else begin
                        w_wd_next = r_wd + 1'b1;
                    end
                end else begin
                    w_wd_next = '0;
                end
            end
            ST_ERR: begin
                w_wd_next = '0;
                if (r_to_count != CNT_MAX) begin
                    w_to_count_next = r_to_count + 1'b1;
                end
                w_state_next = w_own_cyc ? ST_BUSY : ST_IDLE;
            end
            default: begin
                w_wd_next    = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin : p_regs
        if (!wb_rst_n_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_wd       <= '0;
            r_to_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_last     <= w_last_next;
            r_wd       <= w_wd_next;
            r_to_count <= w_to_count_next;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for wb_bus_arbiter: directed table, hand sequences for the
// watchdog corners, and a randomized run against a transaction-level reference model.
module tb_wb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] m_dat, s_adr, s_wdat;
    logic [1:0]  gnt;
    logic [7:0]  to_cnt;

    logic        b_cyc, b_stb;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;
    logic [31:0] b_m_dat, b_s_adr, b_s_dat;
    logic [1:0]  b_gnt;
    logic [1:0]  b_to;

    int n_cmp = 0;
    int n_bad = 0;

    wb_bus_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m_dat_o(m_dat), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .gnt_o(gnt), .to_count_o(to_cnt)
    );

    // Narrow-counter build used only for the saturation check; its decoder never acks.
    wb_bus_arbiter #(.TIMEOUT(3), .TO_W(2)) dut_sat (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_cyc_i(b_cyc), .m0_stb_i(b_stb), .m0_we_i(1'b0), .m0_sel_i(4'd0),
        .m0_adr_i(32'd0), .m0_dat_i(32'd0), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_sel_i(4'd0),
        .m1_adr_i(32'd0), .m1_dat_i(32'd0), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .m_dat_o(b_m_dat), .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we),
        .s_sel_o(b_s_sel), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_ack_i(1'b0),
        .s_dat_i(32'd0), .gnt_o(b_gnt), .to_count_o(b_to)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, required $finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [4:0]  in;    // c0 s0 c1 s1 ack
        logic [1:0]  gnt;
        logic [3:0]  fl;    // s_cyc s_stb m0_ack m1_ack
        logic [31:0] adr;
        logic [31:0] mdat;
    } vec_t;

    vec_t tbl [15];

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [1:0] g, input logic c, input logic st,
                                          input logic we, input logic [3:0] sel,
                                          input logic [31:0] adr, input logic [31:0] dat,
                                          input logic a0, input logic e0, input logic a1,
                                          input logic e1, input logic [31:0] md,
                                          input logic [7:0] to);
        return {11'd0, g, c, st, we, sel, adr, dat, a0, e0, a1, e1, md, to};
    endfunction

    function automatic logic [127:0] snap();
        return pack(gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat,
                    m0_ack, m0_err, m1_ack, m1_err, m_dat, to_cnt);
    endfunction

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b1; m1_sel = 4'hF;
        m0_adr = 32'h3000_0100; m0_dat = 32'h0;
        m1_adr = 32'h3800_0000; m1_dat = 32'hCAFE_0001;
        s_ack = 1'b0; s_dat = 32'h1234_5678;
        b_cyc = 1'b0; b_stb = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model state for the randomized run.
    int owner, last, stall, tocnt;
    bit erring;

    initial begin
        bit rc0, rc1, seen, own_cyc, own_stb;
        int cnt;
        logic [1:0] e_gnt;
        logic e_cyc, e_stb, e_we, act_ok;
        logic [3:0] e_sel;
        logic [31:0] e_adr, e_dat, e_md;

        tbl[0]  = '{5'b11110, 2'b00, 4'b0000, 32'h0,         32'h0};
        tbl[1]  = '{5'b11110, 2'b01, 4'b1100, 32'h3000_0100, 32'h0};
        tbl[2]  = '{5'b11110, 2'b01, 4'b1100, 32'h3000_0100, 32'h0};
        tbl[3]  = '{5'b11111, 2'b01, 4'b1110, 32'h3000_0100, 32'h1234_5678};
        tbl[4]  = '{5'b00110, 2'b01, 4'b0000, 32'h3000_0100, 32'h0};
        tbl[5]  = '{5'b00110, 2'b00, 4'b0000, 32'h0,         32'h0};
        tbl[6]  = '{5'b11111, 2'b10, 4'b1101, 32'h3800_0000, 32'h1234_5678};
        tbl[7]  = '{5'b11000, 2'b10, 4'b0000, 32'h3800_0000, 32'h0};
        tbl[8]  = '{5'b11110, 2'b00, 4'b0000, 32'h0,         32'h0};
        tbl[9]  = '{5'b11111, 2'b01, 4'b1110, 32'h3000_0100, 32'h1234_5678};
        tbl[10] = '{5'b00110, 2'b01, 4'b0000, 32'h3000_0100, 32'h0};
        tbl[11] = '{5'b11110, 2'b00, 4'b0000, 32'h0,         32'h0};
        tbl[12] = '{5'b11111, 2'b10, 4'b1101, 32'h3800_0000, 32'h1234_5678};
        tbl[13] = '{5'b11000, 2'b10, 4'b0000, 32'h3800_0000, 32'h0};
        tbl[14] = '{5'b11000, 2'b00, 4'b0000, 32'h0,         32'h0};

        // Reset held while both masters request: everything stays quiet.
        idle_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        repeat (2) begin
            smp();
            check("reset_outputs", snap(), 128'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table: first grant, single read, alternating contention.
        for (int i = 0; i < 15; i++) begin
            {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = tbl[i].in;
            smp();
            $display("row %0d: gnt=%b s_cyc=%b s_adr=%h ack0=%b ack1=%b m_dat=%h",
                     i, gnt, s_cyc, s_adr, m0_ack, m1_ack, m_dat);
            check($sformatf("table_row_%0d", i),
                  128'({gnt, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, s_adr, m_dat}),
                  128'({tbl[i].gnt, tbl[i].fl, 2'b00, tbl[i].adr, tbl[i].mdat}));
            nxt();
        end

        // Held grant: m1 does 4 writes while m0 waits.
        reset_dut();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        smp();
        check("held_idle_gnt", 128'(gnt), 128'(2'b00));
        nxt();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m1_adr = 32'h3800_0000 + 32'(4 * k);
            m1_dat = 32'hD000_0000 + 32'(k);
            s_ack = 1'b0;
            smp();
            check($sformatf("held_wait_%0d", k), 128'({gnt, s_cyc, s_adr}),
                  128'({2'b10, 1'b1, m1_adr}));
            nxt();
            s_ack = 1'b1;
            smp();
            $display("held write %0d: s_adr=%h s_dat=%h we=%b gnt=%b", k, s_adr, s_wdat, s_we, gnt);
            check($sformatf("held_write_%0d", k),
                  128'({gnt, s_we, s_adr, s_wdat, m1_ack, m0_ack}),
                  128'({2'b10, 1'b1, m1_adr, m1_dat, 1'b1, 1'b0}));
            nxt();
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        smp();
        check("held_drop", 128'({gnt, s_cyc}), 128'({2'b10, 1'b0}));
        nxt();
        smp();
        check("held_dead_cycle", 128'(gnt), 128'(2'b00));
        nxt();
        smp();
        check("held_m0_granted", 128'({gnt, s_adr}), 128'({2'b01, 32'h3000_0100}));

        // Timeout: TIMEOUT stalled strobe cycles, then one error cycle.
        reset_dut();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h3000_0200;
        smp();
        nxt();
        for (int k = 1; k <= TO; k++) begin
            smp();
            check($sformatf("timeout_stall_%0d", k), 128'({s_stb, m0_err}), 128'(2'b10));
            nxt();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b1;
        smp();
        $display("timeout: m0_err=%b s_stb=%b gnt=%b", m0_err, s_stb, gnt);
        check("timeout_err_cycle", 128'({m0_err, s_stb, s_cyc, m0_ack, m_dat, gnt}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 2'b01}));
        nxt();
        s_ack = 1'b0;
        smp();
        check("timeout_count", 128'({to_cnt, gnt, m0_err}), 128'({8'd1, 2'b00, 1'b0}));
        nxt();

        // Boundary: ack lands in the last allowed cycle.
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h3000_0300;
        smp();
        nxt();
        for (int k = 1; k < TO; k++) begin
            smp();
            check($sformatf("boundary_stall_%0d", k), 128'({s_stb, m0_ack, m0_err}), 128'(3'b100));
            nxt();
        end
        s_ack = 1'b1;
        smp();
        $display("boundary: m0_ack=%b m0_err=%b m_dat=%h", m0_ack, m0_err, m_dat);
        check("boundary_ack", 128'({m0_ack, m0_err, s_stb, m_dat}),
              128'({1'b1, 1'b0, 1'b1, 32'h1234_5678}));
        nxt();
        s_ack = 1'b0; m0_stb = 1'b0;
        smp();
        check("boundary_no_err", 128'({m0_err, gnt}), 128'({1'b0, 2'b01}));
        nxt();
        m0_cyc = 1'b0;
        smp();
        nxt();
        smp();
        check("boundary_count", 128'({to_cnt, gnt}), 128'({8'd1, 2'b00}));

        // Saturation on the 2-bit counter build.
        reset_dut();
        for (int n = 1; n <= 5; n++) begin
            b_cyc = 1'b1; b_stb = 1'b1;
            cnt = 0;
            seen = 1'b0;
            while (!seen && cnt < 12) begin
                smp();
                if (b_m0_err) seen = 1'b1;
                else begin
                    cnt++;
                    nxt();
                end
            end
            check($sformatf("sat_err_seen_%0d", n), 128'(seen), 128'(1'b1));
            check($sformatf("sat_err_latency_%0d", n), 128'(cnt), 128'(4));
            check($sformatf("sat_err_bus_%0d", n), 128'({b_gnt, b_s_cyc, b_s_stb, b_m0_ack}),
                  128'({2'b01, 3'b000}));
            b_cyc = 1'b0; b_stb = 1'b0;
            nxt();
            smp();
            $display("sat timeout %0d: to_count=%0d", n, b_to);
            check($sformatf("sat_count_%0d", n), 128'({b_to, b_gnt}),
                  128'({(n < 3) ? 2'(n) : 2'd3, 2'b00}));
            nxt();
        end

        // Reset asserted mid-transfer drops the bus without waiting for a clock edge.
        reset_dut();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        smp();
        nxt();
        smp();
        check("async_pre", 128'({s_cyc, s_stb, gnt}), 128'({2'b11, 2'b01}));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_drop", 128'({s_cyc, s_stb, gnt}), 128'(4'b0000));
        @(posedge clk);
        #1 rst_n = 1'b1;
        smp();
        check("async_after_idle", 128'(gnt), 128'(2'b00));
        nxt();
        smp();
        check("async_regrant_m0", 128'(gnt), 128'(2'b01));
        nxt();

        // Randomized run against the reference model.
        reset_dut();
        owner = -1; last = 1; stall = 0; tocnt = 0; erring = 1'b0;
        rc0 = 1'b0; rc1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) rc0 = ~rc0;
            if ($urandom_range(5) == 0) rc1 = ~rc1;
            m0_cyc = rc0; m0_stb = rc0 & ($urandom_range(4) != 0);
            m1_cyc = rc1; m1_stb = rc1 & ($urandom_range(4) != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            m0_adr = $urandom; m1_adr = $urandom; m0_dat = $urandom; m1_dat = $urandom;
            s_ack = ((i / 60) % 3 == 2) ? 1'b0 : ($urandom_range(2) == 0);
            s_dat = $urandom;
            smp();

            own_cyc = (owner == 0) ? m0_cyc : m1_cyc;
            own_stb = (owner == 0) ? m0_stb : m1_stb;
            act_ok  = (owner >= 0) && !erring;
            e_gnt = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
            e_cyc = act_ok ? own_cyc : 1'b0;
            e_stb = act_ok ? own_stb : 1'b0;
            e_we  = act_ok ? ((owner == 0) ? m0_we : m1_we) : 1'b0;
            e_sel = act_ok ? ((owner == 0) ? m0_sel : m1_sel) : 4'd0;
            e_adr = act_ok ? ((owner == 0) ? m0_adr : m1_adr) : 32'd0;
            e_dat = act_ok ? ((owner == 0) ? m0_dat : m1_dat) : 32'd0;
            e_md  = (act_ok && s_ack) ? s_dat : 32'd0;
            check($sformatf("random_cycle_%0d", i), snap(),
                  pack(e_gnt, e_cyc, e_stb, e_we, e_sel, e_adr, e_dat,
                       act_ok && owner == 0 && s_ack, erring && owner == 0,
                       act_ok && owner == 1 && s_ack, erring && owner == 1,
                       e_md, 8'(tocnt)));
            if (act_ok && s_ack && own_stb)
                $display("random %0d: m%0d ack adr=%h", i, owner, e_adr);

            if (owner < 0) begin
                if ((m0_cyc && m0_stb) || (m1_cyc && m1_stb)) begin
                    if (m0_cyc && m0_stb && m1_cyc && m1_stb) owner = 1 - last;
                    else owner = (m0_cyc && m0_stb) ? 0 : 1;
                    last = owner;
                end
                stall = 0;
            end else if (erring) begin
                erring = 1'b0;
                if (tocnt < 255) tocnt++;
                if (!own_cyc) owner = -1;
                stall = 0;
            end else if (!own_cyc) begin
                owner = -1;
                stall = 0;
            end else if (own_stb && !s_ack) begin
                stall++;
                if (stall == TO) begin
                    erring = 1'b1;
                    stall = 0;
                end
            end else begin
                stall = 0;
            end
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
